// File: rtl/alm_product_accumulator.sv
// alm_product_accumulator: accumulates approximate products into per-frame saturating dot-product results
module alm_product_accumulator #(
    parameter int P_BW   = 64,
    parameter int ACC_BW = 72,
    parameter int CNT_BW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sync_clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [P_BW-1:0]   in_product,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_BW-1:0] out_sum,
    output logic [CNT_BW-1:0] out_count,
    output logic              out_sat
);
    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t state, state_d;
    logic [ACC_BW-1:0] acc, sum_sat;
    logic [ACC_BW:0]   sum_ext;
    logic [CNT_BW-1:0] cnt, cnt_sat;
    logic sat_flag, ovf, accept, handoff;

    assign in_ready = !(out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign handoff  = out_valid && out_ready;

    // One spare carry bit detects sum overflow; a count already at max also counts as overflow
    always_comb begin
        sum_ext = {1'b0, acc} + {{(ACC_BW + 1 - P_BW){1'b0}}, in_product};
        sum_sat = sum_ext[ACC_BW] ? '1 : sum_ext[ACC_BW-1:0];
        cnt_sat = &cnt ? cnt : cnt + 1'b1;
        ovf     = sum_ext[ACC_BW] | (&cnt);
        state_d = state;
        if (sync_clr)
            state_d = EMPTY;
        else if (accept)
            state_d = in_last ? EMPTY : ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            acc       <= '0;
            cnt       <= '0;
            sat_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else begin
            state <= state_d;
            if (sync_clr) begin
                acc       <= '0;
                cnt       <= '0;
                sat_flag  <= 1'b0;
                out_valid <= 1'b0;
            end else if (accept && in_last) begin
                out_sum   <= sum_sat;
                out_count <= cnt_sat;
                out_sat   <= sat_flag | ovf;
                out_valid <= 1'b1;
                acc       <= '0;
                cnt       <= '0;
                sat_flag  <= 1'b0;
            end else begin
                if (accept) begin
                    acc      <= sum_sat;
                    cnt      <= cnt_sat;
                    sat_flag <= sat_flag | ovf;
                end
                if (handoff)
                    out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alm_product_accumulator.sv
// tb_alm_product_accumulator: directed and random frames checked against a queue-based frame model
module tb_alm_product_accumulator;
    localparam int P_BW = 8, ACC_BW = 10, CNT_BW = 16;
    localparam int ACC_MAX = (1 << ACC_BW) - 1;

    logic clk = 0, rst_n = 1, sync_clr = 0, in_valid = 0, in_last = 0, out_ready = 1;
    logic [P_BW-1:0] in_product = 0;
    logic in_ready, out_valid, out_sat;
    logic [ACC_BW-1:0] out_sum;
    logic [CNT_BW-1:0] out_count;

    alm_product_accumulator #(.P_BW(P_BW), .ACC_BW(ACC_BW), .CNT_BW(CNT_BW)) dut (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_product(in_product), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    typedef struct { int sum; int cnt; bit sat; } res_t;
    res_t q[$];
    int fsum = 0, fcnt = 0;
    int checks = 0, errors = 0;
    bit rnd_rdy = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a frame is the plain sum of accepted products, clamped at the end
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out_valid", out_valid, 0);
            check("rst_out_sum", out_sum, 0);
            check("rst_out_count", out_count, 0);
            check("rst_out_sat", out_sat, 0);
            q.delete();
            fsum = 0;
            fcnt = 0;
        end else begin
            automatic bit exp_rdy = !(q.size() > 0 && !out_ready);
            check("out_valid", out_valid, q.size() > 0);
            check("in_ready", in_ready, exp_rdy);
            if (q.size() > 0) begin
                check("out_sum", out_sum, q[0].sum);
                check("out_count", out_count, q[0].cnt);
                check("out_sat", out_sat, q[0].sat);
            end
            if (sync_clr) begin
                q.delete();
                fsum = 0;
                fcnt = 0;
            end else begin
                if (q.size() > 0 && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy) begin
                    fsum += int'(in_product);
                    fcnt++;
                    if (in_last) begin
                        q.push_back('{sum: (fsum > ACC_MAX) ? ACC_MAX : fsum, cnt: fcnt, sat: fsum > ACC_MAX});
                        fsum = 0;
                        fcnt = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int p, input bit last);
        bit ok = 0;
        in_valid = 1;
        in_product = P_BW'(p);
        in_last = last;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        if (!ok) check("accept_timeout", 0, 1);
        in_valid = 0;
        in_product = P_BW'($urandom);
        in_last = 1'($urandom);
    endtask

    initial begin
        #1 rst_n = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
        // basic frame
        send(6, 0); send(12, 0); send(20, 1);
        repeat (2) tick();
        // backpressure: held result stalls beats until drained
        out_ready = 0;
        send(5, 1);
        in_valid = 1; in_product = 7; in_last = 0;
        repeat (3) tick();
        out_ready = 1;
        tick();
        in_valid = 0;
        out_ready = 0;
        send(9, 1);
        in_valid = 1; in_product = 1; in_last = 1;
        repeat (2) tick();
        out_ready = 1;
        tick();
        in_valid = 0;
        repeat (2) tick();
        // saturation
        repeat (4) send(255, 0);
        send(255, 1);
        send(1, 1);
        tick();
        // back-to-back single-beat frames
        send(3, 1); send(4, 1); send(0, 1);
        repeat (2) tick();
        // reset mid-frame
        send(100, 0); send(200, 0);
        rst_n = 0;
        tick();
        rst_n = 1;
        send(1, 1);
        repeat (2) tick();
        // sync_clr discards the coincident beat and the partial frame
        send(10, 0); send(20, 0);
        sync_clr = 1; in_valid = 1; in_product = 30; in_last = 1;
        tick();
        sync_clr = 0; in_valid = 0;
        tick();
        send(2, 1);
        repeat (2) tick();
        // random traffic with random backpressure and occasional clears
        rnd_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) tick();
            if ($urandom_range(0, 49) == 0) begin
                sync_clr = 1;
                tick();
                sync_clr = 0;
            end
        end
        rnd_rdy = 0;
        out_ready = 1;
        repeat (4) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
